// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS front end: fetch FSM state encoding, the
// default reset PC, the branch/jump opcode constants and a PC helper.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  // Sequential successor; the 32-bit sum wraps 32'hFFFF_FFFC to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles the instruction-memory read channel, the fetch->decode handoff and
// the resolved control flags coming back from execute.
//   master : the fetch unit (drives imem_req/imem_addr and instr_*)
//   slave  : the environment (memory, decode and execute stages)
// -----------------------------------------------------------------------------
interface instr_fetch_if;
  // instruction-memory read channel
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // handoff to decode
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  // resolved control flow from execute
  logic        branch;
  logic        is_bne;
  logic        alu_zero;
  logic        jump;
  logic [31:0] ex_pc4;
  logic [31:0] br_imm;
  logic [25:0] jump_idx;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready,
           branch, is_bne, alu_zero, jump, ex_pc4, br_imm, jump_idx
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready,
           branch, is_bne, alu_zero, jump, ex_pc4, br_imm, jump_idx
  );
endinterface

// File: rtl/next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Purely combinational redirect decision and target for the executing
// instruction.
//   i_branch, i_is_bne, i_alu_zero, i_jump : resolved control/ALU flags
//   i_ex_pc4   : PC+4 of the executing instruction
//   i_br_imm   : sign-extended branch immediate (word offset)
//   i_jump_idx : 26-bit jump field
//   o_redirect : control flow leaves the sequential path
//   o_target   : new fetch address (jump takes priority over branch)
// -----------------------------------------------------------------------------
module next_pc_calc (
  input  logic        i_branch,
  input  logic        i_is_bne,
  input  logic        i_alu_zero,
  input  logic        i_jump,
  input  logic [31:0] i_ex_pc4,
  input  logic [31:0] i_br_imm,
  input  logic [25:0] i_jump_idx,
  output logic        o_redirect,
  output logic [31:0] o_target
);

  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;

  // BEQ is taken on zero, BNE on non-zero: XOR folds both into one test.
  assign o_redirect   = i_jump | (i_branch & (i_alu_zero ^ i_is_bne));
  assign w_br_target  = i_ex_pc4 + (i_br_imm << 2);
  assign w_jmp_target = {i_ex_pc4[31:28], i_jump_idx, 2'b00};
  assign o_target     = i_jump ? w_jmp_target : w_br_target;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Single-outstanding-request instruction fetch unit with a one-entry output
// buffer and redirect handling (branch/jump resolved in execute).
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : instr_fetch_if.master -- memory read channel, decode handoff and
//         execute control flags
// Parameter RESET_PC: first fetch address after reset (word aligned).
// -----------------------------------------------------------------------------
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc,    w_pc_nxt;
  logic [31:0]  r_pend,  w_pend_nxt;
  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;
  logic         w_capture;
  logic         w_redirect;
  logic [31:0]  w_target;

  next_pc_calc u_next_pc (
    .i_branch   (bus.branch),
    .i_is_bne   (bus.is_bne),
    .i_alu_zero (bus.alu_zero),
    .i_jump     (bus.jump),
    .i_ex_pc4   (bus.ex_pc4),
    .i_br_imm   (bus.br_imm),
    .i_jump_idx (bus.jump_idx),
    .o_redirect (w_redirect),
    .o_target   (w_target)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_FETCH;

      ST_FETCH: begin
        if (w_redirect) begin
          if (bus.imem_ack) begin
            // Returned word is on the wrong path: drop it and refetch.
            w_pc_nxt = w_target;
          end else begin
            // The read must complete at its original address, so the new
            // target waits in r_pend until the memory acknowledges.
            w_pend_nxt  = w_target;
            w_state_nxt = ST_FLUSH;
          end
        end else if (bus.imem_ack) begin
          w_capture   = 1'b1;
          w_pc_nxt    = pc_plus4(r_pc);
          w_state_nxt = ST_HOLD;
        end
      end

      ST_FLUSH: begin
        if (bus.imem_ack) begin
          w_pc_nxt    = w_redirect ? w_target : r_pend;
          w_state_nxt = ST_FETCH;
        end else if (w_redirect) begin
          w_pend_nxt = w_target;
        end
      end

      ST_HOLD: begin
        // A redirect squashes the buffered word even if decode takes it now.
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = ST_FETCH;
        end else if (bus.instr_ready) begin
          w_state_nxt = ST_FETCH;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_pend     <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_pend  <= w_pend_nxt;
      if (w_capture) begin
        r_instr    <= bus.imem_rdata;
        r_instr_pc <= r_pc;
      end
    end
  end

  // Outputs decode registered state only; r_pc doubles as the in-flight
  // address, which keeps imem_addr stable through FLUSH.
  assign bus.imem_req    = (r_state == ST_FETCH) || (r_state == ST_FLUSH);
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = (r_state == ST_HOLD);
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Random and directed stimulus for instr_fetch, checked against a
// transaction-level model of the fetch stream. A second instance with
// RESET_PC = 32'hFFFF_FFFC covers address wrap.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
  import mips_pkg::*;

  logic clk;
  logic rst_a;
  logic rst_b;

  instr_fetch_if bus_a ();
  instr_fetch_if bus_b ();

  instr_fetch dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the fetch stream for dut_a.
  logic [31:0] exp_pc;     // address of the next instruction decode should see
  logic [31:0] m_addr;     // address of the current memory request
  logic [31:0] m_instr;
  logic [31:0] m_instr_pc;
  bit          m_req;
  bit          m_valid;
  bit          m_idle;
  bit          m_squash;   // current request was overtaken by a redirect

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: a unique word per address with a real opcode field.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] op;
    case (a[3:2])
      2'd0:    op = OP_BEQ;
      2'd1:    op = OP_BNE;
      2'd2:    op = OP_J;
      default: op = 6'h23;
    endcase
    return {op, a[27:2]};
  endfunction

  task automatic model_new_txn();
    m_req    = 1'b1;
    m_valid  = 1'b0;
    m_addr   = exp_pc;
    m_squash = 1'b0;
  endtask

  // One clock of dut_a: drive inputs at the falling edge, update the model,
  // then compare outputs at the next falling edge.
  task automatic step(input bit ack, input bit ready, input bit br, input bit bne,
                      input bit zero, input bit jmp, input logic [31:0] pc4,
                      input logic [31:0] imm, input logic [25:0] idx);
    bit          taken;
    logic [31:0] tgt;
    bus_a.imem_ack    = ack;
    bus_a.imem_rdata  = ack ? mem_word(bus_a.imem_addr) : $urandom;
    bus_a.instr_ready = ready;
    bus_a.branch      = br;
    bus_a.is_bne      = bne;
    bus_a.alu_zero    = zero;
    bus_a.jump        = jmp;
    bus_a.ex_pc4      = pc4;
    bus_a.br_imm      = imm;
    bus_a.jump_idx    = idx;
    taken = jmp || (br && (zero != bne));
    tgt   = jmp ? {pc4[31:28], idx, 2'b00} : pc4 + imm * 32'd4;
    #1 check("valid_before_edge", 32'(bus_a.instr_valid), 32'(m_valid));

    if (m_idle) begin
      m_idle = 1'b0;
      model_new_txn();
    end else if (m_valid) begin
      if (taken) begin
        exp_pc = tgt;
        model_new_txn();
      end else if (ready) begin
        exp_pc = exp_pc + 32'd4;
        model_new_txn();
      end
    end else if (m_req) begin
      if (taken) begin
        exp_pc   = tgt;
        m_squash = 1'b1;
      end
      if (ack) begin
        if (m_squash) begin
          model_new_txn();
        end else begin
          m_req      = 1'b0;
          m_valid    = 1'b1;
          m_instr_pc = m_addr;
          m_instr    = mem_word(m_addr);
        end
      end
    end

    @(posedge clk);
    @(negedge clk);
    check("imem_req", 32'(bus_a.imem_req), 32'(m_req));
    check("instr_valid", 32'(bus_a.instr_valid), 32'(m_valid));
    if (m_req) check("imem_addr", bus_a.imem_addr, m_addr);
    if (m_valid) begin
      check("instr_pc", bus_a.instr_pc, m_instr_pc);
      check("instr", bus_a.instr, m_instr);
    end
  endtask

  task automatic nop(input bit ack, input bit ready);
    step(ack, ready, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0);
  endtask

  task automatic rnd_step(input int ack_pct, input int ready_pct, input int redir_pct);
    bit          ack, ready, br, bne, zero, jmp;
    logic [31:0] pc4, imm;
    logic [25:0] idx;
    ack   = ($urandom_range(99) < ack_pct);
    ready = ($urandom_range(99) < ready_pct);
    jmp   = ($urandom_range(99) < redir_pct / 2);
    br    = ($urandom_range(99) < redir_pct);
    bne   = 1'($urandom_range(1));
    zero  = 1'($urandom_range(1));
    pc4   = {20'h0, 10'($urandom_range(1023)), 2'b00};
    imm   = 32'($urandom_range(63)) - 32'd32;
    idx   = 26'($urandom_range(4095));
    step(ack, ready, br, bne, zero, jmp, pc4, imm, idx);
  endtask

  // Advance dut_a until it presents an instruction (bounded).
  task automatic to_hold();
    for (int i = 0; i < 20; i++) begin
      if (m_valid) break;
      nop(1'b1, 1'b0);
    end
    check("to_hold_reached", 32'(m_valid), 32'd1);
  endtask

  // Asynchronous reset pulse on dut_a starting between clock edges.
  task automatic apply_reset_a();
    #3 rst_a = 1'b1;
    #1;
    check("rst_instr_valid", 32'(bus_a.instr_valid), 32'd0);
    check("rst_imem_req", 32'(bus_a.imem_req), 32'd0);
    check("rst_imem_addr", bus_a.imem_addr, RESET_PC_DEFAULT);
    check("rst_instr", bus_a.instr, 32'd0);
    check("rst_instr_pc", bus_a.instr_pc, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_a    = 1'b0;
    exp_pc   = RESET_PC_DEFAULT;
    m_idle   = 1'b1;
    m_req    = 1'b0;
    m_valid  = 1'b0;
    m_squash = 1'b0;
    m_addr   = RESET_PC_DEFAULT;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved_instr;
    logic [31:0] saved_pc;

    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_b.imem_ack = 1'b0;   bus_b.imem_rdata = '0;  bus_b.instr_ready = 1'b0;
    bus_b.branch = 1'b0;     bus_b.is_bne = 1'b0;    bus_b.alu_zero = 1'b0;
    bus_b.jump = 1'b0;       bus_b.ex_pc4 = '0;      bus_b.br_imm = '0;
    bus_b.jump_idx = '0;
    bus_a.imem_ack = 1'b0;   bus_a.imem_rdata = '0;  bus_a.instr_ready = 1'b0;
    bus_a.branch = 1'b0;     bus_a.is_bne = 1'b0;    bus_a.alu_zero = 1'b0;
    bus_a.jump = 1'b0;       bus_a.ex_pc4 = '0;      bus_a.br_imm = '0;
    bus_a.jump_idx = '0;
    #2 rst_b = 1'b1;

    @(negedge clk);
    apply_reset_a();

    // In-order fetch with ack two cycles after each request.
    nop(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("seq_req_addr", bus_a.imem_addr, 32'(k * 4));
      nop(1'b0, 1'b1);
      nop(1'b0, 1'b1);
      nop(1'b1, 1'b1);
      check("seq_instr_pc", bus_a.instr_pc, 32'(k * 4));
      nop(1'b0, 1'b1);
    end

    // Decode stalls five cycles; buffered word must stay put.
    to_hold();
    saved_instr = bus_a.instr;
    saved_pc    = bus_a.instr_pc;
    for (int i = 0; i < 5; i++) begin
      nop(1'b0, 1'b0);
      check("stall_instr", bus_a.instr, saved_instr);
      check("stall_instr_pc", bus_a.instr_pc, saved_pc);
    end
    nop(1'b0, 1'b1);
    check("after_stall_addr", bus_a.imem_addr, saved_pc + 32'd4);

    // Taken BEQ while holding: 0x10 + (-2 << 2) = 0x08.
    to_hold();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'hFFFF_FFFE, 26'h0);
    check("beq_addr", bus_a.imem_addr, 32'h0000_0008);
    check("beq_dropped", 32'(bus_a.instr_valid), 32'd0);
    // Same flags as BNE: not taken, word stays buffered.
    to_hold();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'hFFFF_FFFE, 26'h0);
    check("bne_kept", 32'(bus_a.instr_valid), 32'd1);
    nop(1'b0, 1'b1);

    // Jump while the fetch awaits its ack.
    nop(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000_0000, 32'h0, 26'h40);
    nop(1'b1, 1'b0);
    check("jump_flush_dropped", 32'(bus_a.instr_valid), 32'd0);
    check("jump_addr", bus_a.imem_addr, 32'h2000_0100);
    nop(1'b1, 1'b1);

    // Randomized traffic with varying pressure.
    for (int i = 0; i < 600; i++) rnd_step(50, 60, 10);
    for (int i = 0; i < 400; i++) rnd_step(90, 90, 30);
    for (int i = 0; i < 400; i++) rnd_step(20, 20, 5);

    // Reset in the middle of a request and while holding a word.
    to_hold();
    nop(1'b0, 1'b1);
    apply_reset_a();
    for (int i = 0; i < 40; i++) rnd_step(60, 70, 10);
    to_hold();
    apply_reset_a();
    nop(1'b0, 1'b1);
    check("refetch_reset_pc", bus_a.imem_addr, RESET_PC_DEFAULT);
    for (int i = 0; i < 40; i++) rnd_step(60, 70, 10);

    // dut_b: reset PC at the top of the address space wraps to 0.
    @(negedge clk);
    rst_b = 1'b0;
    check("b_rel_req", 32'(bus_b.imem_req), 32'd0);
    check("b_rel_addr", bus_b.imem_addr, 32'hFFFF_FFFC);
    @(posedge clk); @(negedge clk);
    check("b_first_req", 32'(bus_b.imem_req), 32'd1);
    check("b_first_addr", bus_b.imem_addr, 32'hFFFF_FFFC);
    bus_b.imem_ack   = 1'b1;
    bus_b.imem_rdata = mem_word(32'hFFFF_FFFC);
    @(posedge clk); @(negedge clk);
    bus_b.imem_ack = 1'b0;
    check("b_valid", 32'(bus_b.instr_valid), 32'd1);
    check("b_instr_pc", bus_b.instr_pc, 32'hFFFF_FFFC);
    check("b_instr", bus_b.instr, mem_word(32'hFFFF_FFFC));
    bus_b.instr_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("b_wrap_req", 32'(bus_b.imem_req), 32'd1);
    check("b_wrap_addr", bus_b.imem_addr, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset; bits [1:0] SHALL be 0.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned read address; SHALL be stable while imem_req=1 until imem_ack.
REQ-006 imem_ack  input  1  read complete; imem_rdata valid this cycle; ignored when imem_req=0.
REQ-007 imem_rdata  input  32  instruction word.
REQ-008 instr_valid  output  1  instr/instr_pc hold a fetched instruction for decode.
REQ-009 instr  output  32  instruction word to the decoder (Op=[31:26], Funct=[5:0]).
REQ-010 instr_pc  output  32  address of instr.
REQ-011 instr_ready  input  1  decode accepts instr when instr_valid=1.
REQ-012 branch, is_bne, alu_zero, jump  input  1 each  resolved control/ALU flags of the executing instruction.
REQ-013 ex_pc4  input  32  PC+4 of the executing instruction.
REQ-014 br_imm  input  32  sign-extended branch immediate; jump_idx  input  26  jump field.

Function
REQ-015 Redirect SHALL be asserted when jump=1, or branch=1 and (alu_zero XOR is_bne)=1.
REQ-016 Target SHALL be {ex_pc4[31:28], jump_idx, 2'b00} when jump=1, else ex_pc4 + (br_imm<<2) mod 2^32; jump SHALL win over branch.
REQ-017 Sequential PC SHALL be pc+4 mod 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 FSM states: IDLE, FETCH, HOLD, FLUSH.
REQ-019 IDLE: outputs inactive; SHALL go to FETCH the next cycle unconditionally.
REQ-020 FETCH: imem_req=1, imem_addr=pc; on imem_ack without redirect SHALL capture instr=imem_rdata, instr_pc=pc, pc<=pc+4, go to HOLD.
REQ-021 FETCH with redirect and imem_ack in the same cycle: data SHALL be discarded, pc<=target, remain in FETCH.
REQ-022 FETCH with redirect and no imem_ack: target SHALL be stored in a pending register, go to FLUSH; imem_req/imem_addr unchanged.
REQ-023 FLUSH: imem_req=1 with the old address; a further redirect SHALL overwrite the pending target; on imem_ack the data SHALL be discarded, pc<=pending (or the same-cycle redirect target), go to FETCH.
REQ-024 HOLD: instr_valid=1, imem_req=0; instr_ready=1 without redirect SHALL go to FETCH; instr_ready=0 SHALL hold instr and instr_pc stable.
REQ-025 HOLD with redirect: buffered instr SHALL be dropped regardless of instr_ready, pc<=target, go to FETCH; decode SHALL squash that cycle's handshake.
REQ-026 instr_valid SHALL be registered and 1 only in HOLD; no combinational path from redirect inputs to instr_valid.
REQ-027 Latency: imem_ack in cycle N SHALL give instr_valid=1 in N+1; next imem_req no earlier than the cycle after acceptance.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, pc=RESET_PC, pending=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-029 Reset mid-request SHALL abandon the transaction; the first imem_req after release SHALL be to RESET_PC no earlier than the second clk edge after deassertion.

Structure
REQ-030 Shared package mips_pkg SHALL hold the fetch state enum, RESET_PC default and opcode constants (BEQ 6'b000100, BNE 6'b000101, J 6'b000010).
REQ-031 Taken/target logic (REQ-015/016) SHALL be a combinational sub-module next_pc_calc.

Verification
REQ-032 Reset release, imem_ack 2 cycles after each req, instr_ready=1 -> addresses 0,4,8 in order, instr_pc matches, instr_valid one cycle per ack.
REQ-033 In HOLD, instr_ready=0 for 5 cycles -> instr, instr_pc stable, imem_req=0; ready=1 -> next fetch at instr_pc+4.
REQ-034 branch=1, is_bne=0, alu_zero=1, ex_pc4=32'h10, br_imm=32'hFFFF_FFFE in HOLD -> next imem_addr=32'h08, held instr dropped; is_bne=1 same case -> no redirect.
REQ-035 jump=1, jump_idx=26'h40, ex_pc4=32'h2000_0000 while FETCH awaits ack -> FLUSH, ack data never shown on instr, next imem_addr=32'h2000_0100.
REQ-036 RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0; rst pulse mid-request -> instr_valid=0 immediately, refetch from RESET_PC.
